// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand-stage bus: ID-side operands and control, hazard/forwarding
// inputs from later stages, and the registered EX-side outputs.
interface id_ex_operand_stage_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
);
   // Decoded instruction from ID
   logic              id_valid_i;
   logic [REG_AW-1:0] id_rs1_addr_i;
   logic [REG_AW-1:0] id_rs2_addr_i;
   logic [REG_AW-1:0] id_rd_addr_i;
   logic [XLEN-1:0]   id_rs1_data_i;
   logic [XLEN-1:0]   id_rs2_data_i;
   logic [XLEN-1:0]   id_imm_i;
   logic              id_uses_rs2_i;
   logic              id_alu_src_i;
   logic [3:0]        id_alu_ctrl_i;
   logic              id_reg_write_i;
   logic              id_mem_read_i;
   logic              id_mem_write_i;
   logic              id_mem_to_reg_i;
   logic              id_branch_i;
   logic              flush_i;

   // Forwarding sources
   logic              exm_reg_write_i;
   logic [REG_AW-1:0] exm_rd_addr_i;
   logic [XLEN-1:0]   exm_result_i;
   logic              wb_reg_write_i;
   logic [REG_AW-1:0] wb_rd_addr_i;
   logic [XLEN-1:0]   wb_data_i;

   // EX-side outputs
   logic [XLEN-1:0]   src1_o;
   logic [XLEN-1:0]   src2_o;
   logic [3:0]        alu_ctrl_o;
   logic [XLEN-1:0]   store_data_o;
   logic [REG_AW-1:0] ex_rd_addr_o;
   logic              ex_valid_o;
   logic              ex_reg_write_o;
   logic              ex_mem_read_o;
   logic              ex_mem_write_o;
   logic              ex_mem_to_reg_o;
   logic              ex_branch_o;
   logic              load_use_stall_o;

   modport master (
      output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
             id_rs1_data_i, id_rs2_data_i, id_imm_i, id_uses_rs2_i,
             id_alu_src_i, id_alu_ctrl_i, id_reg_write_i, id_mem_read_i,
             id_mem_write_i, id_mem_to_reg_i, id_branch_i, flush_i,
             exm_reg_write_i, exm_rd_addr_i, exm_result_i,
             wb_reg_write_i, wb_rd_addr_i, wb_data_i,
      input  src1_o, src2_o, alu_ctrl_o, store_data_o, ex_rd_addr_o,
             ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
             ex_mem_to_reg_o, ex_branch_o, load_use_stall_o
   );

   modport slave (
      input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
             id_rs1_data_i, id_rs2_data_i, id_imm_i, id_uses_rs2_i,
             id_alu_src_i, id_alu_ctrl_i, id_reg_write_i, id_mem_read_i,
             id_mem_write_i, id_mem_to_reg_i, id_branch_i, flush_i,
             exm_reg_write_i, exm_rd_addr_i, exm_result_i,
             wb_reg_write_i, wb_rd_addr_i, wb_data_i,
      output src1_o, src2_o, alu_ctrl_o, store_data_o, ex_rd_addr_o,
             ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
             ex_mem_to_reg_o, ex_branch_o, load_use_stall_o
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU. Resolves EX/MEM and MEM/WB
// forwarding, detects load-use hazards and inserts bubbles on stall/flush.
module id_ex_operand_stage #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
) (
   input logic                 clk_i,
   input logic                 rst_n,
   id_ex_operand_stage_if.slave bus
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs1_addr;
      logic [REG_AW-1:0] rs2_addr;
      logic [REG_AW-1:0] rd_addr;
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [XLEN-1:0]   imm;
      logic              alu_src;
      logic [3:0]        alu_ctrl;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              mem_to_reg;
      logic              branch;
   } ex_reg_t;

   ex_reg_t         ex_d, ex_q;
   logic            stall;
   logic [XLEN-1:0] fwd_rs1, fwd_rs2;

   // Load-use hazard: a load in EX whose destination ID is about to read.
   always_comb begin
      stall = 1'b0;
      if (bus.id_valid_i && ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0)) begin
         if ((ex_q.rd_addr == bus.id_rs1_addr_i) ||
             (bus.id_uses_rs2_i && (ex_q.rd_addr == bus.id_rs2_addr_i))) begin
            stall = 1'b1;
         end
      end
   end

   // Next register contents: flush beats stall, both load an all-zero bubble.
   always_comb begin
      ex_d = '0;
      if (!bus.flush_i && !stall) begin
         ex_d.valid      = bus.id_valid_i;
         ex_d.rs1_addr   = bus.id_rs1_addr_i;
         ex_d.rs2_addr   = bus.id_rs2_addr_i;
         ex_d.rd_addr    = bus.id_rd_addr_i;
         ex_d.rs1_data   = bus.id_rs1_data_i;
         ex_d.rs2_data   = bus.id_rs2_data_i;
         ex_d.imm        = bus.id_imm_i;
         ex_d.alu_src    = bus.id_alu_src_i;
         ex_d.alu_ctrl   = bus.id_alu_ctrl_i;
         ex_d.reg_write  = bus.id_reg_write_i;
         ex_d.mem_read   = bus.id_mem_read_i;
         ex_d.mem_write  = bus.id_mem_write_i;
         ex_d.mem_to_reg = bus.id_mem_to_reg_i;
         ex_d.branch     = bus.id_branch_i;
      end
   end

   // ID/EX pipeline register.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   // rs1 forwarding: EX/MEM first, then MEM/WB, never for x0.
   always_comb begin
      fwd_rs1 = ex_q.rs1_data;
      if (bus.exm_reg_write_i && (bus.exm_rd_addr_i != '0) &&
          (bus.exm_rd_addr_i == ex_q.rs1_addr)) begin
         fwd_rs1 = bus.exm_result_i;
      end else if (bus.wb_reg_write_i && (bus.wb_rd_addr_i != '0) &&
                   (bus.wb_rd_addr_i == ex_q.rs1_addr)) begin
         fwd_rs1 = bus.wb_data_i;
      end
   end

   // rs2 forwarding, same priority as rs1.
   always_comb begin
      fwd_rs2 = ex_q.rs2_data;
      if (bus.exm_reg_write_i && (bus.exm_rd_addr_i != '0) &&
          (bus.exm_rd_addr_i == ex_q.rs2_addr)) begin
         fwd_rs2 = bus.exm_result_i;
      end else if (bus.wb_reg_write_i && (bus.wb_rd_addr_i != '0) &&
                   (bus.wb_rd_addr_i == ex_q.rs2_addr)) begin
         fwd_rs2 = bus.wb_data_i;
      end
   end

   // ALU operands are zeroed while EX holds a bubble.
   always_comb begin
      bus.src1_o       = '0;
      bus.src2_o       = '0;
      bus.store_data_o = '0;
      if (ex_q.valid) begin
         bus.src1_o       = fwd_rs1;
         bus.src2_o       = ex_q.alu_src ? ex_q.imm : fwd_rs2;
         bus.store_data_o = fwd_rs2;
      end
   end

   assign bus.alu_ctrl_o       = ex_q.alu_ctrl;
   assign bus.ex_rd_addr_o     = ex_q.rd_addr;
   assign bus.ex_valid_o       = ex_q.valid;
   assign bus.ex_reg_write_o   = ex_q.reg_write;
   assign bus.ex_mem_read_o    = ex_q.mem_read;
   assign bus.ex_mem_write_o   = ex_q.mem_write;
   assign bus.ex_mem_to_reg_o  = ex_q.mem_to_reg;
   assign bus.ex_branch_o      = ex_q.branch;
   assign bus.load_use_stall_o = stall;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: capture, forwarding, x0 guard,
// load-use stall, flush-over-stall and asynchronous reset.
module tb_id_ex_operand_stage;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   id_ex_operand_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

   id_ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
      .clk_i (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic id_idle();
      bus.id_valid_i      = 1'b0;
      bus.id_rs1_addr_i   = '0;
      bus.id_rs2_addr_i   = '0;
      bus.id_rd_addr_i    = '0;
      bus.id_rs1_data_i   = '0;
      bus.id_rs2_data_i   = '0;
      bus.id_imm_i        = '0;
      bus.id_uses_rs2_i   = 1'b0;
      bus.id_alu_src_i    = 1'b0;
      bus.id_alu_ctrl_i   = 4'b0000;
      bus.id_reg_write_i  = 1'b0;
      bus.id_mem_read_i   = 1'b0;
      bus.id_mem_write_i  = 1'b0;
      bus.id_mem_to_reg_i = 1'b0;
      bus.id_branch_i     = 1'b0;
      bus.flush_i         = 1'b0;
   endtask

   task automatic fwd_idle();
      bus.exm_reg_write_i = 1'b0;
      bus.exm_rd_addr_i   = '0;
      bus.exm_result_i    = '0;
      bus.wb_reg_write_i  = 1'b0;
      bus.wb_rd_addr_i    = '0;
      bus.wb_data_i       = '0;
   endtask

   // Present one instruction on the ID side.
   task automatic id_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                           input logic uses_rs2, input logic alu_src, input logic [3:0] ctrl,
                           input logic rw, input logic mr, input logic mw);
      bus.id_valid_i      = 1'b1;
      bus.id_rs1_addr_i   = rs1;
      bus.id_rs2_addr_i   = rs2;
      bus.id_rd_addr_i    = rd;
      bus.id_rs1_data_i   = d1;
      bus.id_rs2_data_i   = d2;
      bus.id_imm_i        = imm;
      bus.id_uses_rs2_i   = uses_rs2;
      bus.id_alu_src_i    = alu_src;
      bus.id_alu_ctrl_i   = ctrl;
      bus.id_reg_write_i  = rw;
      bus.id_mem_read_i   = mr;
      bus.id_mem_write_i  = mw;
      bus.id_mem_to_reg_i = mr;
      bus.id_branch_i     = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      id_idle();
      fwd_idle();
      #12;
      check("rst_valid", 32'(bus.ex_valid_o), 32'd0);
      check("rst_ctrl", 32'(bus.alu_ctrl_o), 32'd0);
      check("rst_src1", bus.src1_o, 32'd0);
      check("rst_stall", 32'(bus.load_use_stall_o), 32'd0);
      rst_n = 1'b1;
      tick();

      // ADDI x2, x1, 7 with x1 = 5
      id_instr(5'd1, 5'd4, 5'd2, 32'd5, 32'h99, 32'd7, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
      tick();
      check("addi_src1", bus.src1_o, 32'd5);
      check("addi_src2", bus.src2_o, 32'd7);
      check("addi_ctrl", 32'(bus.alu_ctrl_o), 32'h2);
      check("addi_valid", 32'(bus.ex_valid_o), 32'd1);
      check("addi_rd", 32'(bus.ex_rd_addr_o), 32'd2);
      check("addi_rw", 32'(bus.ex_reg_write_o), 32'd1);
      check("addi_store", bus.store_data_o, 32'h99);

      // ADD x8, x3, x4: rs1 forwarded from both stages
      id_instr(5'd3, 5'd4, 5'd8, 32'hdead, 32'h44, 32'd0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
      tick();
      id_idle();
      bus.exm_reg_write_i = 1'b1; bus.exm_rd_addr_i = 5'd3; bus.exm_result_i = 32'h10;
      bus.wb_reg_write_i  = 1'b1; bus.wb_rd_addr_i  = 5'd3; bus.wb_data_i    = 32'h20;
      #1;
      check("dfwd_src1", bus.src1_o, 32'h10);
      check("dfwd_src2", bus.src2_o, 32'h44);
      bus.exm_reg_write_i = 1'b0;
      #1;
      check("wbfwd_src1", bus.src1_o, 32'h20);
      bus.exm_reg_write_i = 1'b1; bus.wb_rd_addr_i = 5'd4;
      #1;
      check("mix_src1", bus.src1_o, 32'h10);
      check("mix_src2", bus.src2_o, 32'h20);
      fwd_idle();
      #1;
      check("nofwd_src1", bus.src1_o, 32'hdead);

      // x0 guard
      id_instr(5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
      tick();
      id_idle();
      bus.exm_reg_write_i = 1'b1; bus.exm_rd_addr_i = 5'd0; bus.exm_result_i = 32'h55;
      bus.wb_reg_write_i  = 1'b1; bus.wb_rd_addr_i  = 5'd0; bus.wb_data_i    = 32'h66;
      #1;
      check("x0_src1", bus.src1_o, 32'd0);
      check("x0_src2", bus.src2_o, 32'd0);
      fwd_idle();

      // LW x5, 4(x1) then ADD x6, x5, x1
      id_instr(5'd1, 5'd0, 5'd5, 32'h100, 32'd0, 32'd4, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
      tick();
      check("lw_mr", 32'(bus.ex_mem_read_o), 32'd1);
      check("lw_src2", bus.src2_o, 32'd4);
      // rs2 matches but is not read: no hazard
      id_instr(5'd1, 5'd5, 5'd6, 32'h77, 32'd0, 32'd0, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
      #1;
      check("nors2_stall", 32'(bus.load_use_stall_o), 32'd0);
      id_instr(5'd5, 5'd1, 5'd6, 32'h77, 32'h100, 32'd0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
      #1;
      check("lu_stall", 32'(bus.load_use_stall_o), 32'd1);
      tick();
      check("lu_bubble_valid", 32'(bus.ex_valid_o), 32'd0);
      check("lu_bubble_mr", 32'(bus.ex_mem_read_o), 32'd0);
      check("lu_bubble_src1", bus.src1_o, 32'd0);
      check("lu_stall_clear", 32'(bus.load_use_stall_o), 32'd0);
      tick();
      check("lu_add_valid", 32'(bus.ex_valid_o), 32'd1);
      check("lu_add_rd", 32'(bus.ex_rd_addr_o), 32'd6);
      check("lu_add_src1", bus.src1_o, 32'h77);

      // LW x7 then SW x7, 8(x2) with flush
      id_instr(5'd1, 5'd0, 5'd7, 32'h200, 32'd0, 32'd0, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
      tick();
      id_instr(5'd2, 5'd7, 5'd0, 32'h300, 32'h11, 32'd8, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1);
      #1;
      check("sw_stall", 32'(bus.load_use_stall_o), 32'd1);
      bus.flush_i = 1'b1;
      tick();
      check("fl_valid", 32'(bus.ex_valid_o), 32'd0);
      check("fl_mw", 32'(bus.ex_mem_write_o), 32'd0);
      check("fl_rw", 32'(bus.ex_reg_write_o), 32'd0);
      bus.flush_i = 1'b0;
      tick();
      check("sw_mw", 32'(bus.ex_mem_write_o), 32'd1);
      bus.exm_reg_write_i = 1'b1; bus.exm_rd_addr_i = 5'd7; bus.exm_result_i = 32'habc;
      #1;
      check("sw_src2", bus.src2_o, 32'd8);
      check("sw_store", bus.store_data_o, 32'habc);
      check("sw_src1", bus.src1_o, 32'h300);
      fwd_idle();

      // Asynchronous reset while holding an ADD
      id_instr(5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'd0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
      tick();
      check("add_valid", 32'(bus.ex_valid_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(bus.ex_valid_o), 32'd0);
      check("arst_src1", bus.src1_o, 32'd0);
      check("arst_ctrl", 32'(bus.alu_ctrl_o), 32'd0);
      check("arst_rw", 32'(bus.ex_reg_write_o), 32'd0);
      tick();
      rst_n = 1'b1;
      id_instr(5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'd0, 1'b1, 1'b0, 4'b0011, 1'b1, 1'b0, 1'b0);
      #1;
      check("post_rst_hold", 32'(bus.ex_valid_o), 32'd0);
      tick();
      check("post_rst_valid", 32'(bus.ex_valid_o), 32'd1);
      check("post_rst_ctrl", 32'(bus.alu_ctrl_o), 32'h3);
      check("post_rst_src2", bus.src2_o, 32'h6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register for the 5-stage RISC-V core, sitting directly upstream of the ALU.
- Captures decoded operands and control from ID on each clock.
- Resolves EX/MEM and MEM/WB forwarding and drives the ALU's src1, src2 and ALU_control.
- Detects load-use hazards (requests a stall) and inserts bubbles on stall or branch flush.

Parameters:
- XLEN, 32, data width of operands, immediate and forwarded values
- REG_AW, 5, register-file address width

Ports:
- clk_i  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_valid_i  input  1  ID holds a real instruction
- id_rs1_addr_i  input  REG_AW  rs1 index
- id_rs2_addr_i  input  REG_AW  rs2 index
- id_rd_addr_i  input  REG_AW  destination index
- id_rs1_data_i  input  XLEN  register-file read 1
- id_rs2_data_i  input  XLEN  register-file read 2
- id_imm_i  input  XLEN  sign-extended immediate
- id_uses_rs2_i  input  1  instruction reads rs2 (R-type, store, branch)
- id_alu_src_i  input  1  1 selects immediate for src2
- id_alu_ctrl_i  input  4  ALU operation code
- id_reg_write_i  input  1  register-write control
- id_mem_read_i  input  1  memory-read control
- id_mem_write_i  input  1  memory-write control
- id_mem_to_reg_i  input  1  memory-to-register control
- id_branch_i  input  1  branch control
- flush_i  input  1  branch taken; kill the instruction entering EX
- exm_reg_write_i  input  1  EX/MEM writes a register
- exm_rd_addr_i  input  REG_AW  EX/MEM destination
- exm_result_i  input  XLEN  EX/MEM ALU result
- wb_reg_write_i  input  1  MEM/WB writes a register
- wb_rd_addr_i  input  REG_AW  MEM/WB destination
- wb_data_i  input  XLEN  MEM/WB write-back value
- src1_o  output  XLEN  to ALU src1
- src2_o  output  XLEN  to ALU src2
- alu_ctrl_o  output  4  to ALU_control
- store_data_o  output  XLEN  forwarded rs2 for store
- ex_rd_addr_o  output  REG_AW  destination in EX
- ex_valid_o  output  1  EX holds a real instruction
- ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_branch_o  output  1 each  registered controls
- load_use_stall_o  output  1  freeze PC and IF/ID this cycle

Behaviour:
- Reset (rst_n low, asynchronous): all registered fields and ex_valid_o cleared to 0, so every control output is 0 and alu_ctrl_o is 4'b0000. Registers release on the first rising edge after rst_n goes high.
- Latency: ID inputs appear on the EX outputs one clock later.
- load_use_stall_o (combinational):
  - asserted when id_valid_i & ex_valid_o & ex_mem_read_o & (ex_rd != 0)
  - and (ex_rd == id_rs1_addr_i, or id_uses_rs2_i & ex_rd == id_rs2_addr_i).
- Register update priority on each edge:
  1. flush_i: load a bubble.
  2. load_use_stall_o: load a bubble.
  3. Otherwise capture all ID inputs, with ex_valid = id_valid_i.
- A bubble means valid and all write/memory/branch controls are 0, alu_ctrl is 0, and data fields are 0.
- Simultaneous flush and stall: flush wins. The stall output is still driven, and upstream ignores it under flush.
- Forwarding for rs1 and for rs2, evaluated independently:
  - EX/MEM source when exm_reg_write_i, exm_rd_addr_i != 0 and it matches the EX rs index.
  - Otherwise MEM/WB source when wb_reg_write_i, wb_rd_addr_i != 0 and it matches.
  - Otherwise the registered register-file data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- src1_o = forwarded rs1.
- src2_o = ex_alu_src ? registered imm : forwarded rs2.
- store_data_o = forwarded rs2 regardless of alu_src.
- When ex_valid_o is 0: src1_o, src2_o and store_data_o are 0.
- No arithmetic is performed here; widths pass through unchanged.

Test Plan:
- Reset: assert rst_n low mid-cycle with the stage holding an ADD -> all outputs 0 immediately, without waiting for a clock edge; after release, the next captured instruction appears one cycle later.
- Plain capture: ADDI with rs1 data 5, imm 7, alu_src 1, alu_ctrl 0010 -> next cycle src1_o=5, src2_o=7, alu_ctrl_o=0010, ex_valid_o=1.
- Double forward: EX/MEM rd=x3 result=0x10 and MEM/WB rd=x3 data=0x20, EX instruction with rs1=x3 -> src1_o=0x10.
- x0 guard: EX/MEM rd=x0 with reg_write=1, EX rs1=x0 (regfile data 0) -> src1_o=0, no forward.
- Load-use: LW x5 in EX followed by ADD x6,x5,x1 in ID -> load_use_stall_o=1; next cycle ex_valid_o=0; the ADD, held in ID, is captured one cycle later with stall 0.
- Flush over stall: flush_i=1 while load_use_stall_o=1 -> bubble loaded; SW in ID with uses_rs2 and matching rs2 flagged stall; store_data_o follows rs2 forwarding while src2_o=imm.
